// File: rtl/rat_io_responder.sv
// Port-I/O responder: OUT writes go to LED/7-seg latches and a down-counting interval timer; IN reads are combinational.
// Write latency 1 cycle; read latency 0 cycles; no backpressure (every strobe is accepted), expire raises a held interrupt.
`timescale 1ns/1ps
module rat_io_responder #(
    parameter int PRESCALE    = 100,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] port_id,
    input  logic [7:0] out_port,
    input  logic       io_strb,
    output logic [7:0] in_port,
    output logic       interrupt,
    input  logic [7:0] switches,
    input  logic [3:0] buttons,
    output logic [7:0] leds,
    output logic [7:0] sseg
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [7:0] PORT_SW     = 8'h00;
    localparam logic [7:0] PORT_BTN    = 8'h01;
    localparam logic [7:0] PORT_STAT   = 8'h02;
    localparam logic [7:0] PORT_CNT_LO = 8'h03;
    localparam logic [7:0] PORT_CNT_HI = 8'h04;
    localparam logic [7:0] PORT_RLD_LO = 8'h30;
    localparam logic [7:0] PORT_RLD_HI = 8'h31;
    localparam logic [7:0] PORT_CTRL   = 8'h32;
    localparam logic [7:0] PORT_ACK    = 8'h33;
    localparam logic [7:0] PORT_LEDS   = 8'h40;
    localparam logic [7:0] PORT_SSEG   = 8'h41;

    localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);

    state_t      r_state;
    logic [7:0]  r_leds;
    logic [7:0]  r_sseg;
    logic [15:0] r_reload;
    logic        r_en;
    logic        r_auto;
    logic [15:0] r_count;
    logic [15:0] r_presc;
    logic        r_pending;

    logic [SYNC_STAGES-1:0][7:0] r_sw_sync;
    logic [SYNC_STAGES-1:0][3:0] r_btn_sync;

    state_t      w_state_nxt;
    logic [15:0] w_count_nxt;
    logic [15:0] w_presc_nxt;
    logic        w_en_nxt;
    logic        w_auto_nxt;
    logic        w_pending_nxt;
    logic        w_tick;
    logic        w_expire;
    logic        w_wr_ctrl;
    logic        w_wr_ack;
    logic [15:0] w_reload_eff;

    assign w_wr_ctrl    = io_strb && (port_id == PORT_CTRL);
    assign w_wr_ack     = io_strb && (port_id == PORT_ACK);
    // A zero reload would never reach the count==1 expire point, so it runs as 1.
    assign w_reload_eff = (r_reload == 16'd0) ? 16'd1 : r_reload;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_count   <= 16'd0;
            r_presc   <= 16'd0;
            r_en      <= 1'b0;
            r_auto    <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_presc   <= w_presc_nxt;
            r_en      <= w_en_nxt;
            r_auto    <= w_auto_nxt;
            r_pending <= w_pending_nxt;
        end
    end

    // A control write in a cycle overrides any tick that cycle would have produced.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_presc_nxt = r_presc;
        w_en_nxt    = r_en;
        w_auto_nxt  = r_auto;
        w_tick      = 1'b0;
        w_expire    = 1'b0;
        if (w_wr_ctrl) begin
            w_en_nxt   = out_port[0];
            w_auto_nxt = out_port[1];
            if (out_port[0]) begin
                w_state_nxt = RUN;
                w_count_nxt = w_reload_eff;
                w_presc_nxt = 16'd0;
            end else begin
                w_state_nxt = IDLE;
            end
        end else if (r_state == RUN) begin
            if (r_presc == PRESC_LAST) begin
                w_presc_nxt = 16'd0;
                w_tick      = 1'b1;
            end else begin
                w_presc_nxt = r_presc + 16'd1;
            end
            if (w_tick) begin
                if (r_count == 16'd1) begin
                    w_expire = 1'b1;
                    if (r_auto) begin
                        w_count_nxt = w_reload_eff;
                    end else begin
                        w_en_nxt    = 1'b0;
                        w_count_nxt = 16'd0;
                        w_state_nxt = IDLE;
                    end
                end else if (r_count != 16'd0) begin
                    w_count_nxt = r_count - 16'd1;
                end
            end
        end
        // Expire beats a same-cycle acknowledge so no event is lost.
        w_pending_nxt = w_expire | (r_pending & ~w_wr_ack);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_leds   <= 8'd0;
            r_sseg   <= 8'd0;
            r_reload <= 16'd0;
        end else if (io_strb) begin
            case (port_id)
                PORT_LEDS:   r_leds          <= out_port;
                PORT_SSEG:   r_sseg          <= out_port;
                PORT_RLD_LO: r_reload[7:0]   <= out_port;
                PORT_RLD_HI: r_reload[15:8]  <= out_port;
                default:     ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sw_sync  <= '0;
            r_btn_sync <= '0;
        end else begin
            r_sw_sync  <= {r_sw_sync[SYNC_STAGES-2:0], switches};
            r_btn_sync <= {r_btn_sync[SYNC_STAGES-2:0], buttons};
        end
    end

    always_comb begin
        in_port = 8'h00;
        case (port_id)
            PORT_SW:     in_port = r_sw_sync[SYNC_STAGES-1];
            PORT_BTN:    in_port = {4'b0000, r_btn_sync[SYNC_STAGES-1]};
            PORT_STAT:   in_port = {5'b00000, (r_state == RUN), r_en, r_pending};
            PORT_CNT_LO: in_port = r_count[7:0];
            PORT_CNT_HI: in_port = r_count[15:8];
            default:     in_port = 8'h00;
        endcase
    end

    assign interrupt = r_pending;
    assign leds      = r_leds;
    assign sseg      = r_sseg;

endmodule

// File: tb/tb_rat_io_responder.sv
// Bench for rat_io_responder: directed literal checks plus randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_rat_io_responder;

    localparam int P = 4;
    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] port_id = 8'h00;
    logic [7:0] out_port = 8'h00;
    logic       io_strb = 1'b0;
    logic [7:0] in_port;
    logic       interrupt;
    logic [7:0] switches = 8'h00;
    logic [3:0] buttons = 4'h0;
    logic [7:0] leds;
    logic [7:0] sseg;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rat_io_responder #(.PRESCALE(P), .SYNC_STAGES(S)) dut (
        .clk(clk), .rst(rst), .port_id(port_id), .out_port(out_port),
        .io_strb(io_strb), .in_port(in_port), .interrupt(interrupt),
        .switches(switches), .buttons(buttons), .leds(leds), .sseg(sseg)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: timer as a running flag, a tick counter and a count.
    bit          m_valid = 0;
    logic [7:0]  m_leds, m_sseg;
    logic [15:0] m_reload;
    bit          m_en, m_auto, m_run, m_pending;
    int          m_count, m_presc;
    logic [7:0]  sw_hist[$];
    logic [3:0]  bt_hist[$];

    function automatic logic [7:0] m_read(input logic [7:0] a);
        logic [7:0] sw;
        logic [3:0] bt;
        sw = (sw_hist.size() >= S) ? sw_hist[S-1] : 8'h00;
        bt = (bt_hist.size() >= S) ? bt_hist[S-1] : 4'h0;
        case (a)
            8'h00:   return sw;
            8'h01:   return {4'h0, bt};
            8'h02:   return {5'b0, m_run, m_en, m_pending};
            8'h03:   return 8'(m_count);
            8'h04:   return 8'(m_count >> 8);
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_step();
        bit expire;
        int eff;
        if (rst) begin
            m_leds = 0; m_sseg = 0; m_reload = 0;
            m_en = 0; m_auto = 0; m_run = 0; m_pending = 0;
            m_count = 0; m_presc = 0;
            sw_hist.delete();
            bt_hist.delete();
            m_valid = 1;
            return;
        end
        sw_hist.push_front(switches);
        if (sw_hist.size() > S) void'(sw_hist.pop_back());
        bt_hist.push_front(buttons);
        if (bt_hist.size() > S) void'(bt_hist.pop_back());
        eff = (m_reload == 0) ? 1 : int'(m_reload);
        expire = 0;
        if (io_strb && port_id == 8'h32) begin
            m_en = out_port[0];
            m_auto = out_port[1];
            if (out_port[0]) begin
                m_run = 1; m_count = eff; m_presc = 0;
            end else begin
                m_run = 0;
            end
        end else if (m_run) begin
            m_presc++;
            if (m_presc == P) begin
                m_presc = 0;
                if (m_count == 1) begin
                    expire = 1;
                    if (m_auto) m_count = eff;
                    else begin m_en = 0; m_count = 0; m_run = 0; end
                end else if (m_count > 0) begin
                    m_count--;
                end
            end
        end
        if (io_strb && port_id == 8'h33) m_pending = 0;
        if (expire) m_pending = 1;
        if (io_strb) begin
            case (port_id)
                8'h40: m_leds = out_port;
                8'h41: m_sseg = out_port;
                8'h30: m_reload[7:0] = out_port;
                8'h31: m_reload[15:8] = out_port;
                default: ;
            endcase
        end
    endtask

    always @(posedge clk) model_step();

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (m_valid) begin
                check("cmp_leds", 16'(leds), 16'(m_leds));
                check("cmp_sseg", 16'(sseg), 16'(m_sseg));
                check("cmp_irq", 16'(interrupt), 16'(m_pending));
                check("cmp_in_port", 16'(in_port), 16'(m_read(port_id)));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // Called at a negedge; returns at the negedge after the write edge.
    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        port_id = a; out_port = d; io_strb = 1'b1;
        @(negedge clk);
        io_strb = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] v);
        port_id = a;
        #1 v = in_port;
    endtask

    logic [7:0] v;
    logic [7:0] ptab[16];
    int lat;

    initial begin
        ptab[0] = 8'h00; ptab[1] = 8'h01; ptab[2] = 8'h02; ptab[3] = 8'h03;
        ptab[4] = 8'h04; ptab[5] = 8'h30; ptab[6] = 8'h31; ptab[7] = 8'h32;
        ptab[8] = 8'h33; ptab[9] = 8'h40; ptab[10] = 8'h41; ptab[11] = 8'h7F;
        ptab[12] = 8'h30; ptab[13] = 8'h33; ptab[14] = 8'h02; ptab[15] = 8'h03;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1 check("reset_leds", 16'(leds), 16'h00);
        check("reset_irq", 16'(interrupt), 16'h0);
        rd(8'h02, v); check("reset_status", 16'(v), 16'h00);
        @(negedge clk);

        wr(8'h40, 8'h5A); #1 check("leds_write", 16'(leds), 16'h5A);
        @(negedge clk);
        wr(8'h41, 8'hC3); #1 check("sseg_write", 16'(sseg), 16'hC3);
        @(negedge clk);
        wr(8'h7F, 8'hFF);
        #1 check("bad_port_leds", 16'(leds), 16'h5A);
        check("bad_port_sseg", 16'(sseg), 16'hC3);

        @(negedge clk);
        port_id = 8'h00; switches = 8'hA5;
        @(posedge clk); #1 check("sync_stage1", 16'(in_port), 16'h00);
        @(posedge clk); #1 check("sync_out", 16'(in_port), 16'hA5);
        @(negedge clk);
        rd(8'h55, v); check("unmapped_read", 16'(v), 16'h00);
        @(negedge clk);

        wr(8'h30, 8'h03); wr(8'h31, 8'h00); wr(8'h32, 8'h01);
        lat = 0;
        while (!interrupt && lat < 40) begin @(posedge clk); #1; lat++; end
        check("oneshot_latency", 16'(lat), 16'd12);
        @(negedge clk);
        rd(8'h02, v); check("oneshot_status", 16'(v), 16'h01);
        @(negedge clk);
        wr(8'h33, 8'h00); #1 check("ack_clears", 16'(interrupt), 16'h0);
        rd(8'h02, v); check("idle_status", 16'(v), 16'h00);
        @(negedge clk);

        wr(8'h30, 8'h02); wr(8'h32, 8'h03);
        port_id = 8'h03;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            check("auto_count", 16'(in_port), ((k / 4) % 2 == 0) ? 16'd2 : 16'd1);
            if (k == 7) check("auto_irq_low", 16'(interrupt), 16'h0);
            if (k == 8) check("auto_irq_high", 16'(interrupt), 16'h1);
        end
        @(negedge clk);
        wr(8'h33, 8'h00); #1 check("auto_ack", 16'(interrupt), 16'h0);
        lat = 0;
        while (!interrupt && lat < 20) begin @(posedge clk); #1; lat++; end
        check("auto_rearm", 16'(interrupt), 16'h1);
        @(negedge clk);

        wr(8'h32, 8'h00); wr(8'h33, 8'h00); wr(8'h32, 8'h03);
        repeat (7) @(negedge clk);
        wr(8'h33, 8'h00);
        #1 check("ack_vs_expire", 16'(interrupt), 16'h1);
        @(negedge clk);
        wr(8'h33, 8'h00);
        #1 check("late_ack", 16'(interrupt), 16'h0);

        lat = 0;
        while (!interrupt && lat < 20) begin @(posedge clk); #1; lat++; end
        check("pre_reset_irq", 16'(interrupt), 16'h1);
        @(negedge clk);
        wr(8'h40, 8'h77);
        rd(8'h02, v); check("run_status", 16'(v), 16'h07);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1 check("midrst_irq", 16'(interrupt), 16'h0);
        check("midrst_leds", 16'(leds), 16'h00);
        rd(8'h02, v); check("midrst_status", 16'(v), 16'h00);
        rd(8'h03, v); check("midrst_count_lo", 16'(v), 16'h00);
        rd(8'h04, v); check("midrst_count_hi", 16'(v), 16'h00);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 399) == 0);
            port_id = ptab[$urandom_range(0, 15)];
            if (port_id == 8'h7F) port_id = 8'($urandom);
            io_strb = ($urandom_range(0, 2) == 0);
            out_port = 8'($urandom);
            if (port_id == 8'h30) out_port = 8'($urandom_range(0, 12));
            if (port_id == 8'h31 && $urandom_range(0, 3) != 0) out_port = 8'h00;
            if (port_id == 8'h32 && $urandom_range(0, 2) != 0) io_strb = 1'b0;
            if ($urandom_range(0, 7) == 0) switches = 8'($urandom);
            if ($urandom_range(0, 7) == 0) buttons = 4'($urandom);
        end
        @(negedge clk);
        rst = 1'b0; io_strb = 1'b0;
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rat_io_responder.md
Name: rat_io_responder

Overview:
- Peripheral-side responder for the CPU's port I/O interface (port_id, out_port, io_strb, in_port, interrupt).
- Decodes OUT writes into output latches and a programmable down-counting interval timer.
- Returns IN read data combinationally from port_id.
- Drives the CPU's interrupt input when the timer expires; the interrupt is held until software acknowledges it.

Parameters:
PRESCALE, 100, clk cycles per timer tick (legal range 1..65535)
SYNC_STAGES, 2, flip-flop stages on the switch/button inputs (legal range >=2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
port_id  in  8  port address from the CPU execute stage
out_port  in  8  write data from the CPU
io_strb  in  1  write strobe; one cycle per OUT instruction
in_port  out  8  read data to the CPU; combinational function of port_id
interrupt  out  1  level interrupt request to the CPU
switches  in  8  asynchronous board switches
buttons  in  4  asynchronous board buttons
leds  out  8  LED latch
sseg  out  8  seven-segment latch

Behaviour:
Reset:
- leds=0, sseg=0, interrupt=0.
- reload=0x0000, count=0x0000, prescaler=0, ctrl=0.
- Timer FSM goes to IDLE; synchronizer flops are cleared.

Writes (on posedge clk when io_strb=1):
- 0x40: leds<=out_port.
- 0x41: sseg<=out_port.
- 0x30: reload[7:0]<=out_port.
- 0x31: reload[15:8]<=out_port.
- 0x32: ctrl<=out_port[1:0]. Bit0 is EN, bit1 is AUTO.
- 0x33: acknowledge; clears pending. Data is ignored.
- Any other port: ignored.

Reads (combinational, no side effects):
- 0x00: synchronized switches.
- 0x01: {4'b0, synchronized buttons}.
- 0x02: {5'b0, running, EN, pending}.
- 0x03: count[7:0].
- 0x04: count[15:8].
- Any other port: 0x00.

Timer FSM (states IDLE, RUN):
- IDLE -> RUN on the cycle after a write to 0x32 with bit0=1. On entry: count<=max(reload,1), prescaler<=0.
- RUN, each cycle:
  - prescaler increments.
  - When prescaler==PRESCALE-1, it wraps to 0 and produces a tick.
  - On a tick: if count==1, the timer expires; otherwise count<=count-1.
- On expire:
  - pending<=1.
  - If AUTO=1: count<=max(reload,1) and the FSM stays in RUN.
  - If AUTO=0: EN<=0, count<=0, FSM goes to IDLE.
- RUN -> IDLE on a write to 0x32 with bit0=0. count holds its value, pending is unchanged.
- A write to 0x32 with bit0=1 while in RUN restarts the timer: count reloads and prescaler clears.
- A write to 0x30/0x31 while in RUN affects only the next reload.

Interrupt:
- interrupt = pending (registered).
- If expire and acknowledge occur in the same cycle, expire wins and pending stays 1.
- Expire while pending is already 1 leaves it at 1. There is no counting or queueing of events.

Synchronizers:
- switches and buttons pass through SYNC_STAGES flops.
- Read data lags the pins by SYNC_STAGES cycles.

Reset mid-operation:
- Returns every item to its reset value on the next edge, including pending.

Widths:
- All timer arithmetic is unsigned 16-bit.
- count never underflows below 0.

Test Plan:
1. Write 0x5A to port 0x40, then 0xC3 to port 0x41 -> leds=0x5A and sseg=0xC3 one cycle after each strobe. A write of 0xFF to port 0x7F changes nothing.
2. Drive switches=0xA5 with SYNC_STAGES=2. Set port_id=0x00 -> in_port=0xA5 two cycles after the switch change. port_id=0x55 -> in_port=0x00.
3. PRESCALE=4. Write 0x30=0x03, 0x31=0x00, then 0x32=0x01 -> interrupt rises 12 cycles (±1) after RUN entry. Port 0x02 then reads 0x01. Write 0x33 -> interrupt=0 the next cycle and the FSM is in IDLE.
4. PRESCALE=4, reload=2, ctrl=0x03 (auto-reload) -> expirations every 8 cycles. Acknowledging between expirations makes interrupt re-assert each period. Port 0x03 counts 2,1,2,1,...
5. Acknowledge written in the same cycle as an expire -> interrupt remains 1. A later acknowledge clears it.
6. Assert rst while in RUN with pending=1 -> the next cycle shows interrupt=0, leds=0, port 0x02 reads 0x00, and count=0.
